// File: rtl/uart_tx_cfg_if.sv
// Word handshake into uart_tx_cfg: the host (master) offers words, the transmitter (slave) accepts them.
interface uart_tx_cfg_if #(
  parameter int DATA_W = 8
);
  // A word transfers on a clk edge with s_valid && s_ready; s_data is held while s_valid && !s_ready.
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_W data bits LSB first, optional even/odd parity, 1 or 2 stop bits.
// Define UART_TX_FIFO_EN to buffer words in a FIFO_DEPTH-entry FIFO instead of a single holding register.
module uart_tx_cfg #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         baud_tick,
  input  logic         parity_en,
  input  logic         parity_odd,
  input  logic         stop2,
  uart_tx_cfg_if.slave s,
  output logic         tx,
  output logic         tx_busy,
  output logic         tx_done,
  output logic [2:0]   state_dbg
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  localparam int            CW   = 4;
  localparam logic [CW-1:0] DW_C = CW'(DATA_W);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_cfg: DATA_W must be 5..9");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_cfg: FIFO_DEPTH must be a power of 2, >= 2");
  end

  logic              push, pop, buf_empty, buf_full;
  logic [DATA_W-1:0] head;

  assign s.s_ready = !buf_full;
  assign push      = s.s_valid && !buf_full;

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  // Extra MSB on each pointer tells full from empty when the indices match.
  assign buf_empty = (wr_ptr_q == rd_ptr_q);
  assign buf_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_ptr_d  = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
  assign rd_ptr_d  = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= s.s_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
`else
  logic [DATA_W-1:0] hold_q;
  logic              hold_v_q, hold_v_d;

  assign buf_empty = !hold_v_q;
  assign buf_full  = hold_v_q;
  assign head      = hold_q;

  always_comb begin
    hold_v_d = hold_v_q;
    if (pop)  hold_v_d = 1'b0;
    if (push) hold_v_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q   <= '0;
      hold_v_q <= 1'b0;
    end else begin
      hold_v_q <= hold_v_d;
      if (push) hold_q <= s.s_data;
    end
  end
`endif

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_en_q, par_en_d, par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d, stop_second_q, stop_second_d;
  logic              tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic              frame_end;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    data_d        = data_q;
    par_en_d      = par_en_q;
    par_bit_d     = par_bit_q;
    stop2_d       = stop2_q;
    stop_second_d = stop_second_q;
    tx_d          = tx_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    pop           = 1'b0;
    frame_end     = 1'b0;
    if (baud_tick) begin
      case (state_q)
        S_IDLE: ;
        S_START: begin
          tx_d    = data_q[0];
          data_d  = data_q >> 1;
          cnt_d   = CW'(1);
          state_d = S_DATA;
        end
        S_DATA: begin
          if (cnt_q < DW_C) begin
            tx_d   = data_q[0];
            data_d = data_q >> 1;
            cnt_d  = cnt_q + CW'(1);
          end else if (par_en_q) begin
            tx_d    = par_bit_q;
            state_d = S_PARITY;
          end else begin
            tx_d          = 1'b1;
            stop_second_d = 1'b0;
            state_d       = S_STOP;
          end
        end
        S_PARITY: begin
          tx_d          = 1'b1;
          stop_second_d = 1'b0;
          state_d       = S_STOP;
        end
        S_STOP: begin
          if (stop2_q && !stop_second_q) begin
            stop_second_d = 1'b1;
          end else begin
            done_d    = 1'b1;
            frame_end = 1'b1;
            tx_d      = 1'b1;
            busy_d    = 1'b0;
            state_d   = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
      // Launch a start bit from idle, or straight after the last stop period for gapless frames.
      if ((state_q == S_IDLE || frame_end) && !buf_empty) begin
        pop           = 1'b1;
        data_d        = head;
        par_en_d      = parity_en;
        par_bit_d     = (^head) ^ parity_odd;
        stop2_d       = stop2;
        stop_second_d = 1'b0;
        cnt_d         = '0;
        tx_d          = 1'b0;
        busy_d        = 1'b1;
        state_d       = S_START;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      data_q        <= '0;
      par_en_q      <= 1'b0;
      par_bit_q     <= 1'b0;
      stop2_q       <= 1'b0;
      stop_second_q <= 1'b0;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      data_q        <= data_d;
      par_en_q      <= par_en_d;
      par_bit_q     <= par_bit_d;
      stop2_q       <= stop2_d;
      stop_second_q <= stop_second_d;
      tx_q          <= tx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign tx        = tx_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;
  assign state_dbg = state_q;
endmodule
